// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: software loads up to DEPTH patterns and a dwell period over an
// Avalon-MM slave, then the block writes each pattern to the LED PIO over an Avalon-MM master.
module led_pattern_sequencer #(
   parameter int DEPTH    = 8,
   parameter int PERIOD_W = 24,
   parameter int LED_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [1:0]  m_address,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DWELL = 2'd2
   } state_t;

   localparam logic [3:0] DEPTH_L = 4'(DEPTH);

   state_t              state_r;
   state_t              state_n;
   logic                run_r;
   logic                run_n;
   logic                done_r;
   logic                done_n;
   logic                loop_r;
   logic [2:0]          index_r;
   logic [2:0]          index_n;
   logic [2:0]          index_inc;
   logic [PERIOD_W-1:0] cnt_r;
   logic [PERIOD_W-1:0] cnt_n;
   logic [PERIOD_W-1:0] period_r;
   logic [PERIOD_W-1:0] eff_period;
   logic [3:0]          length_r;
   logic [3:0]          eff_len;
   logic [LED_W-1:0]    pat_r [0:7];
   logic                m_write_n_r;
   logic                m_write_n_n;
   logic [LED_W-1:0]    m_data_r;
   logic [LED_W-1:0]    m_data_n;
   logic                slave_wr;
   logic                start_wr;
   logic                stop_wr;
   logic                last_step;
   logic                busy;
   logic                unused_wdata;

   assign slave_wr     = chipselect && !write_n;
   assign start_wr     = slave_wr && (address == 4'd0) && writedata[0];
   assign stop_wr      = slave_wr && (address == 4'd0) && !writedata[0];
   assign busy         = (state_r != IDLE);
   assign index_inc    = index_r + 3'd1;
   assign last_step    = ({1'b0, index_r} >= (eff_len - 4'd1));
   assign unused_wdata = ^writedata[31:PERIOD_W];

   // Zero LENGTH/PERIOD mean "one"; LENGTH is clamped to the table depth
   always_comb begin
      if (length_r == 4'd0) begin
         eff_len = 4'd1;
      end else if (length_r > DEPTH_L) begin
         eff_len = DEPTH_L;
      end else begin
         eff_len = length_r;
      end
      if (period_r == '0) begin
         eff_period = PERIOD_W'(1);
      end else begin
         eff_period = period_r;
      end
   end

   // Software-visible configuration registers and pattern table
   always_ff @(posedge clk) begin
      if (reset) begin
         loop_r   <= 1'b0;
         period_r <= '0;
         length_r <= 4'd0;
         for (int i = 0; i < 8; i++) begin
            pat_r[i] <= '0;
         end
      end else if (slave_wr) begin
         case (address)
            4'd0: loop_r   <= writedata[1];
            4'd1: period_r <= writedata[PERIOD_W-1:0];
            4'd2: length_r <= writedata[3:0];
            default: begin
               if (address[3] && ({1'b0, address[2:0]} < DEPTH_L)) begin
                  pat_r[address[2:0]] <= writedata[LED_W-1:0];
               end
            end
         endcase
      end
   end

   // Sequencer next-state and master-port next values
   always_comb begin
      state_n     = state_r;
      run_n       = run_r;
      done_n      = done_r;
      index_n     = index_r;
      cnt_n       = cnt_r;
      m_write_n_n = m_write_n_r;
      m_data_n    = m_data_r;
      case (state_r)
         IDLE: begin
            if (start_wr) begin
               state_n     = WRITE;
               run_n       = 1'b1;
               done_n      = 1'b0;
               index_n     = 3'd0;
               m_write_n_n = 1'b0;
               m_data_n    = pat_r[0];
            end else begin
               state_n = IDLE;
            end
         end
         WRITE: begin
            // A stop cannot abort the transfer; it only clears run so acceptance ends the run
            if (!m_waitrequest) begin
               m_write_n_n = 1'b1;
               if (stop_wr || !run_r) begin
                  state_n = IDLE;
                  run_n   = 1'b0;
               end else begin
                  state_n = DWELL;
                  cnt_n   = eff_period;
               end
            end else if (stop_wr) begin
               run_n = 1'b0;
            end else begin
               run_n = run_r;
            end
         end
         DWELL: begin
            if (stop_wr || !run_r) begin
               state_n = IDLE;
               run_n   = 1'b0;
            end else if (cnt_r == PERIOD_W'(1)) begin
               if (!last_step) begin
                  state_n     = WRITE;
                  index_n     = index_inc;
                  m_write_n_n = 1'b0;
                  m_data_n    = pat_r[index_inc];
               end else if (loop_r) begin
                  state_n     = WRITE;
                  index_n     = 3'd0;
                  m_write_n_n = 1'b0;
                  m_data_n    = pat_r[0];
               end else begin
                  state_n = IDLE;
                  run_n   = 1'b0;
                  done_n  = 1'b1;
               end
            end else begin
               cnt_n = cnt_r - PERIOD_W'(1);
            end
         end
         default: begin
            state_n     = IDLE;
            run_n       = 1'b0;
            m_write_n_n = 1'b1;
         end
      endcase
   end

   // Sequencer state and registered master outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         run_r       <= 1'b0;
         done_r      <= 1'b0;
         index_r     <= 3'd0;
         cnt_r       <= '0;
         m_write_n_r <= 1'b1;
         m_data_r    <= '0;
      end else begin
         state_r     <= state_n;
         run_r       <= run_n;
         done_r      <= done_n;
         index_r     <= index_n;
         cnt_r       <= cnt_n;
         m_write_n_r <= m_write_n_n;
         m_data_r    <= m_data_n;
      end
   end

   // Zero-latency slave read mux
   always_comb begin
      readdata = 32'd0;
      case (address)
         4'd0: readdata = {30'd0, loop_r, run_r};
         4'd1: readdata = {{(32-PERIOD_W){1'b0}}, period_r};
         4'd2: readdata = {28'd0, length_r};
         4'd3: readdata = {21'd0, index_r, 6'd0, done_r, busy};
         default: begin
            if (address[3] && ({1'b0, address[2:0]} < DEPTH_L)) begin
               readdata = {{(32-LED_W){1'b0}}, pat_r[address[2:0]]};
            end else begin
               readdata = 32'd0;
            end
         end
      endcase
   end

   assign m_address   = 2'd0;
   assign m_write_n   = m_write_n_r;
   assign m_writedata = {{(32-LED_W){1'b0}}, m_data_r};

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed test-plan scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_led_pattern_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [1:0]  m_address;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic        m_waitrequest;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_pattern_sequencer #(.DEPTH(8), .PERIOD_W(24), .LED_W(8)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .m_address(m_address), .m_write_n(m_write_n), .m_writedata(m_writedata),
      .m_waitrequest(m_waitrequest)
   );

   // model: a run is "busy"; inside it either a transfer is outstanding or dwell cycles remain
   bit         md_busy, md_xfer, md_run, md_done, md_loop, md_wn;
   int         md_left, md_idx;
   logic [23:0] md_period;
   logic [3:0]  md_len;
   logic [7:0]  md_pat [8];
   logic [7:0]  md_wd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic model_launch();
      md_xfer = 1'b1;
      md_wn   = 1'b0;
      md_wd   = md_pat[md_idx];
   endtask

   task automatic model_step();
      bit wr, start, stop, run_before;
      int len, per;
      if (reset) begin
         md_busy = 0; md_xfer = 0; md_run = 0; md_done = 0; md_loop = 0;
         md_left = 0; md_idx = 0; md_period = '0; md_len = '0;
         md_wn = 1; md_wd = '0;
         for (int i = 0; i < 8; i++) md_pat[i] = '0;
         return;
      end
      wr    = chipselect && !write_n;
      start = wr && (address == 4'd0) && writedata[0];
      stop  = wr && (address == 4'd0) && !writedata[0];
      len   = (md_len == 0) ? 1 : ((md_len > 8) ? 8 : int'(md_len));
      per   = (md_period == 0) ? 1 : int'(md_period);
      run_before = md_run;
      if (!md_busy) begin
         if (start) begin
            md_busy = 1; md_run = 1; md_done = 0; md_idx = 0;
            model_launch();
         end
      end else if (md_xfer) begin
         if (stop) md_run = 0;
         if (!m_waitrequest) begin
            md_xfer = 0;
            md_wn   = 1;
            if (!run_before || stop) begin
               md_busy = 0; md_run = 0;
            end else begin
               md_left = per;
            end
         end
      end else if (stop) begin
         md_busy = 0; md_run = 0;
      end else begin
         md_left--;
         if (md_left == 0) begin
            if (md_idx + 1 < len) begin
               md_idx++;
               model_launch();
            end else if (md_loop) begin
               md_idx = 0;
               model_launch();
            end else begin
               md_busy = 0; md_run = 0; md_done = 1;
            end
         end
      end
      if (wr) begin
         if (address == 4'd0) md_loop = writedata[1];
         else if (address == 4'd1) md_period = writedata[23:0];
         else if (address == 4'd2) md_len = writedata[3:0];
         else if (address >= 4'd8) md_pat[address - 4'd8] = writedata[7:0];
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [3:0] a);
      logic [2:0] idx3;
      idx3 = md_idx[2:0];
      if (a == 4'd0) return {30'd0, md_loop, md_run};
      if (a == 4'd1) return {8'd0, md_period};
      if (a == 4'd2) return {28'd0, md_len};
      if (a == 4'd3) return {21'd0, idx3, 6'd0, md_done, md_busy};
      if (a >= 4'd8) return {24'd0, md_pat[a - 4'd8]};
      return 32'd0;
   endfunction

   // per-cycle comparison against the model
   initial begin
      @(posedge clk);
      model_step();
      forever begin
         @(negedge clk);
         check("cmp m_write_n", {31'd0, m_write_n}, {31'd0, md_wn});
         check("cmp m_writedata", m_writedata, {24'd0, md_wd});
         check("cmp m_address", {30'd0, m_address}, 32'd0);
         check("cmp readdata", readdata, exp_read(address));
         @(posedge clk);
         model_step();
      end
   end

   // master-port monitor: accepted writes and cycles with the strobe low
   logic [7:0] acc_data[$];
   int         acc_cyc[$];
   logic [7:0] low_data[$];
   int         low_cnt = 0;
   int         cyc = 0;
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset && m_write_n === 1'b0) begin
            low_cnt++;
            low_data.push_back(m_writedata[7:0]);
            if (!m_waitrequest) begin
               acc_data.push_back(m_writedata[7:0]);
               acc_cyc.push_back(cyc);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      tick();
      chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0; address = 4'd3;
   endtask

   task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
      address = a;
      #1;
      check(name, readdata, exp);
      address = 4'd3;
   endtask

   task automatic clear_mon();
      acc_data.delete(); acc_cyc.delete(); low_data.delete(); low_cnt = 0;
   endtask

   task automatic check_seq(input string name, input int n, input logic [7:0] base, input bit shift);
      check({name, " count"}, acc_data.size(), n);
      for (int i = 0; i < n && i < acc_data.size(); i++) begin
         check({name, " data"}, {24'd0, acc_data[i]},
               shift ? {24'd0, 8'(base << i)} : {24'd0, base});
      end
   endtask

   logic [7:0] exp_loop [4] = '{8'h01, 8'h02, 8'h04, 8'h01};

   initial begin
      bit wrap_seen;
      int prev_idx, n, n0, r;
      logic [3:0] a;
      reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 4'd3;
      writedata = 32'd0; m_waitrequest = 1'b0;
      tick(); tick();
      check("reset m_write_n", {31'd0, m_write_n}, 32'd1);
      check("reset m_writedata", m_writedata, 32'd0);
      rd_check("reset status", 4'd3, 32'd0);
      reset = 1'b0;
      tick();

      // single pass of three patterns, period 4
      bus_write(4'd8, 32'h01); bus_write(4'd9, 32'h02); bus_write(4'd10, 32'h04);
      bus_write(4'd2, 32'd3);  bus_write(4'd1, 32'd4);
      clear_mon();
      bus_write(4'd0, 32'h1);
      repeat (25) tick();
      check_seq("t1 seq", 3, 8'h01, 1'b1);
      for (int i = 1; i < acc_cyc.size(); i++) check("t1 spacing", acc_cyc[i] - acc_cyc[i-1], 5);
      rd_check("t1 status", 4'd3, 32'h202);
      rd_check("t1 ctrl", 4'd0, 32'h0);

      // looping run with index wrap
      clear_mon();
      bus_write(4'd0, 32'h3);
      wrap_seen = 1'b0;
      prev_idx = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (prev_idx == 2 && readdata[10:8] == 3'd0) wrap_seen = 1'b1;
         prev_idx = int'(readdata[10:8]);
      end
      for (int i = 0; i < 4 && i < acc_data.size(); i++)
         check("t2 loop data", {24'd0, acc_data[i]}, {24'd0, exp_loop[i]});
      check("t2 enough writes", {31'd0, acc_data.size() >= 4}, 32'd1);
      check("t2 index wrap", {31'd0, wrap_seen}, 32'd1);

      // stop while the transfer is stalled
      m_waitrequest = 1'b1;
      n = 0;
      while (m_write_n !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      check("t4 reached write", {31'd0, m_write_n}, 32'd0);
      n0 = acc_data.size();
      bus_write(4'd0, 32'h0);
      tick();
      m_waitrequest = 1'b0;
      tick();
      check("t4 transfer completes", acc_data.size(), n0 + 1);
      repeat (20) tick();
      check("t4 no more writes", acc_data.size(), n0 + 1);
      address = 4'd3;
      #1;
      check("t4 busy/done", readdata & 32'h3, 32'h0);
      if (acc_data.size() > 0)
         check("t4 leds hold", m_writedata, {24'd0, acc_data[acc_data.size()-1]});

      // first write stalled for three cycles
      clear_mon();
      m_waitrequest = 1'b1;
      bus_write(4'd0, 32'h1);
      tick(); tick(); tick();
      m_waitrequest = 1'b0;
      tick();
      check("t3 low cycles", low_cnt, 4);
      for (int i = 0; i < low_data.size(); i++) check("t3 stable data", {24'd0, low_data[i]}, 32'h01);
      repeat (20) tick();
      check_seq("t3 seq", 3, 8'h01, 1'b1);
      if (acc_cyc.size() >= 2) check("t3 dwell after accept", acc_cyc[1] - acc_cyc[0], 5);
      rd_check("t3 status", 4'd3, 32'h202);

      // LENGTH=0, PERIOD=0
      bus_write(4'd2, 32'd0); bus_write(4'd1, 32'd0);
      clear_mon();
      bus_write(4'd0, 32'h1);
      repeat (10) tick();
      check_seq("t5 single", 1, 8'h01, 1'b0);
      rd_check("t5 status", 4'd3, 32'h002);

      // LENGTH=12 clamps to 8 entries
      for (int i = 3; i < 8; i++) bus_write(4'(8 + i), 32'(1 << i));
      bus_write(4'd2, 32'd12); bus_write(4'd1, 32'd2);
      clear_mon();
      bus_write(4'd0, 32'h1);
      repeat (40) tick();
      check_seq("t5 clamp", 8, 8'h01, 1'b1);
      rd_check("t5 length readback", 4'd2, 32'd12);
      rd_check("t5 clamp status", 4'd3, 32'h702);

      // reset during DWELL
      bus_write(4'd1, 32'd10);
      bus_write(4'd0, 32'h1);
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      check("t6 dwell reset m_write_n", {31'd0, m_write_n}, 32'd1);
      rd_check("t6 dwell reset status", 4'd3, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) rd_check("t6 regs zero", 4'(i), 32'd0);

      // reset during a stalled WRITE
      bus_write(4'd8, 32'h5A);
      m_waitrequest = 1'b1;
      bus_write(4'd0, 32'h1);
      tick();
      check("t6 stalled write", {31'd0, m_write_n}, 32'd0);
      reset = 1'b1;
      tick();
      check("t6 write reset m_write_n", {31'd0, m_write_n}, 32'd1);
      check("t6 write reset data", m_writedata, 32'd0);
      rd_check("t6 write reset status", 4'd3, 32'd0);
      reset = 1'b0;
      m_waitrequest = 1'b0;
      for (int i = 0; i < 16; i++) rd_check("t6 regs zero 2", 4'(i), 32'd0);
      tick();

      // randomized traffic checked by the per-cycle model comparison
      for (int c = 0; c < 4000; c++) begin
         m_waitrequest = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 599) == 0);
         r = $urandom_range(0, 15);
         if (r < 2) begin
            a = 4'($urandom_range(0, 15));
            chipselect = 1'b1;
            write_n = 1'b0;
            address = a;
            if (a == 4'd0)      writedata = ($urandom & 32'hFFFF_FFFE) | 32'($urandom_range(0, 4) != 0);
            else if (a == 4'd1) writedata = $urandom & 32'hFF00_0007;
            else if (a == 4'd2) writedata = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 12));
            else                writedata = $urandom;
         end else begin
            chipselect = 1'($urandom_range(0, 1));
            write_n = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
            address = 4'($urandom_range(0, 15));
            writedata = $urandom;
         end
         tick();
      end
      reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
